// File: rtl/axi_seq_pkg.sv
// Shared types and default constants for the AXI transaction sequencer.
package axi_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGapW,
    StWrPulse,
    StWrWait,
    StGapR,
    StRdPulse,
    StRdWait,
    StDone
  } axi_seq_state_e;

  localparam int unsigned AXI_SEQ_GAP_DEFAULT     = 16;
  localparam int unsigned AXI_SEQ_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/axi_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module axi_seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/axi_txn_sequencer.sv
// Write-then-read stimulus sequencer driving axi_verif_top start pulses.
// Optional wait-state watchdog enabled by defining AXI_SEQ_TIMEOUT_EN.
module axi_txn_sequencer
  import axi_seq_pkg::*;
#(
  parameter int unsigned ITER_W         = 8,
  parameter int unsigned GAP_CYCLES     = AXI_SEQ_GAP_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = AXI_SEQ_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iters,
  input  logic              write_done,
  input  logic              read_done,
  input  logic              read_error,
  output logic              start_write_txn,
  output logic              start_read_txn,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ITER_W-1:0] iter_count,
  output logic [ITER_W-1:0] error_count,
  output logic              timeout
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES) + 1;

  axi_seq_state_e    state;
  logic [ITER_W-1:0] num_iters_q;
  logic [ITER_W-1:0] iter_next;
  logic [ITER_W-1:0] err_sat;
  logic [ITER_W-1:0] err_final;
  logic              in_gap;
  logic              gap_zero;
  logic              wd_expired;
  logic              timeout_q;

  assign in_gap    = (state == StGapW) || (state == StGapR);
  assign iter_next = iter_count + 1'b1;
  assign err_sat   = (error_count == '1) ? error_count : error_count + 1'b1;
  assign err_final = read_error ? err_sat : error_count;

  // Reloads whenever outside a gap state, so the count is ready on entry.
  axi_seq_timer #(
    .WIDTH(GapW)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (!in_gap),
    .en      (in_gap),
    .load_val(GapW'(GAP_CYCLES - 1)),
    .zero    (gap_zero)
  );

`ifdef AXI_SEQ_TIMEOUT_EN
  localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES) + 1;

  logic in_wait;
  logic wd_zero;

  assign in_wait = (state == StWrWait) || (state == StRdWait);

  axi_seq_timer #(
    .WIDTH(TimW)
  ) u_wd_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (!in_wait),
    .en      (in_wait),
    .load_val(TimW'(TIMEOUT_CYCLES - 1)),
    .zero    (wd_zero)
  );

  assign wd_expired = wd_zero;
  assign timeout    = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= StIdle;
      num_iters_q     <= '0;
      start_write_txn <= 1'b0;
      start_read_txn  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      iter_count      <= '0;
      error_count     <= '0;
      timeout_q       <= 1'b0;
    end else begin
      start_write_txn <= 1'b0;
      start_read_txn  <= 1'b0;
      done            <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy        <= 1'b1;
            iter_count  <= '0;
            error_count <= '0;
            timeout_q   <= 1'b0;
            pass        <= 1'b0;
            if (num_iters == '0) begin
              state <= StDone;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              num_iters_q <= num_iters;
              state       <= StGapW;
            end
          end
        end
        StGapW: begin
          if (gap_zero) begin
            state           <= StWrPulse;
            start_write_txn <= 1'b1;
          end
        end
        StWrPulse: state <= StWrWait;
        StWrWait: begin
          if (write_done) begin
            state <= StGapR;
          end else if (wd_expired) begin
            timeout_q   <= 1'b1;
            error_count <= err_sat;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= StDone;
          end
        end
        StGapR: begin
          if (gap_zero) begin
            state          <= StRdPulse;
            start_read_txn <= 1'b1;
          end
        end
        StRdPulse: state <= StRdWait;
        StRdWait: begin
          if (read_done) begin
            iter_count  <= iter_next;
            error_count <= err_final;
            if (iter_next == num_iters_q) begin
              state <= StDone;
              done  <= 1'b1;
              pass  <= (err_final == '0);
            end else begin
              state <= StGapW;
            end
          end else if (wd_expired) begin
            timeout_q   <= 1'b1;
            error_count <= err_sat;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= StDone;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Scoreboard bench for axi_txn_sequencer: directed runs push expected pulse/done events.
module tb_axi_txn_sequencer;

  localparam int G   = 4;
  localparam int TMO = 64;
  localparam int LAT = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_iters = '0;
  logic       write_done = 1'b0;
  logic       read_done = 1'b0;
  logic       read_error = 1'b0;
  logic       start_write_txn, start_read_txn, busy, done, pass, timeout;
  logic [7:0] iter_count, error_count;

  axi_txn_sequencer #(
    .ITER_W        (8),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_iters      (num_iters),
    .write_done     (write_done),
    .read_done      (read_done),
    .read_error     (read_error),
    .start_write_txn(start_write_txn),
    .start_read_txn (start_read_txn),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .iter_count     (iter_count),
    .error_count    (error_count),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;  // 0 write pulse, 1 read pulse, 2 done
    int cyc;
    int pass;
    int iters;
    int errs;
    int tmo;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(input int kind, input int c, input int p, input int it,
                               input int er, input int tm);
    exp_t e;
    e.kind = kind; e.cyc = c; e.pass = p; e.iters = it; e.errs = er; e.tmo = tm;
    q.push_back(e);
  endfunction

  task automatic check_evt(input int k);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", k, -1);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (k == 2) begin
        chk("done_pass", int'(pass), e.pass);
        chk("done_iter_count", int'(iter_count), e.iters);
        chk("done_error_count", int'(error_count), e.errs);
        chk("done_timeout", int'(timeout), e.tmo);
        chk("done_busy", int'(busy), 1);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (start_write_txn) check_evt(0);
    if (start_read_txn) check_evt(1);
    if (done) check_evt(2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_run(input int n, output int c0);
    num_iters = 8'(n);
    start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
  endtask

  // One write/read iteration with the master answering after lat cycles.
  task automatic run_iter(input int wp, input int lat, input bit err, input bit last,
                          input bit stray, input int ep, input int ei, input int ee,
                          output int nwp);
    int rp;
    nwp = 0;
    if (stray) begin
      wait_until(wp);
      write_done = 1'b1;
      step();
      write_done = 1'b0;
      wait_until(wp + 5);
      start = 1'b1; num_iters = 8'd5; read_done = 1'b1; read_error = 1'b1;
      step();
      start = 1'b0; read_done = 1'b0; read_error = 1'b0;
    end
    wait_until(wp + lat);
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    rp = wp + lat + G + 1;
    push(1, rp, 0, 0, 0, 0);
    wait_until(rp + lat);
    read_done = 1'b1;
    read_error = err;
    if (last) begin
      push(2, rp + lat + 1, ep, ei, ee, 0);
    end else begin
      nwp = rp + lat + G + 1;
      push(0, nwp, 0, 0, 0, 0);
    end
    step();
    read_done = 1'b0;
    read_error = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, wp, nwp, rp;
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_iter_count", int'(iter_count), 0);
    chk("reset_error_count", int'(error_count), 0);
    reset = 1'b1;
    repeat (3) step();

    // Single iteration, no errors.
    start_run(1, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    run_iter(wp, LAT, 1'b0, 1'b1, 1'b0, 1, 1, 0, nwp);
    repeat (3) step();
    chk("busy_after_run", int'(busy), 0);
    chk("pass_held", int'(pass), 1);

    // Three iterations, error on the second read.
    start_run(3, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    run_iter(wp, LAT, 1'b0, 1'b0, 1'b0, 0, 0, 0, nwp);
    run_iter(nwp, LAT, 1'b1, 1'b0, 1'b0, 0, 0, 0, nwp);
    run_iter(nwp, LAT, 1'b0, 1'b1, 1'b0, 0, 3, 1, nwp);
    repeat (3) step();

    // Stray start/read_done in WR_WAIT and write_done in the pulse cycle.
    start_run(2, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    run_iter(wp, LAT, 1'b0, 1'b0, 1'b1, 0, 0, 0, nwp);
    run_iter(nwp, LAT, 1'b0, 1'b1, 1'b0, 1, 2, 0, nwp);
    repeat (3) step();

    // Zero iterations: immediate done.
    start_run(0, c0);
    push(2, c0 + 1, 1, 0, 0, 0);
    repeat (3) step();

    // Reset during the second RD_WAIT aborts the run.
    start_run(3, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    run_iter(wp, LAT, 1'b1, 1'b0, 1'b0, 0, 0, 0, nwp);
    wait_until(nwp + LAT);
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    rp = nwp + LAT + G + 1;
    push(1, rp, 0, 0, 0, 0);
    wait_until(rp + 10);
    chk("pre_reset_iter_count", int'(iter_count), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_start_write_txn", int'(start_write_txn), 0);
    chk("abort_start_read_txn", int'(start_read_txn), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_iter_count", int'(iter_count), 0);
    chk("abort_error_count", int'(error_count), 0);
    chk("abort_timeout", int'(timeout), 0);
    repeat (60) step();

    start_run(1, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    run_iter(wp, LAT, 1'b0, 1'b1, 1'b0, 1, 1, 0, nwp);
    repeat (3) step();

`ifdef AXI_SEQ_TIMEOUT_EN
    // write_done never arrives: watchdog fires after TMO cycles in WR_WAIT.
    start_run(1, c0);
    wp = c0 + G + 1;
    push(0, wp, 0, 0, 0, 0);
    wait_until(wp + TMO);
    chk("timeout_before_expiry", int'(timeout), 0);
    push(2, wp + TMO + 1, 0, 0, 1, 1);
    wait_until(wp + TMO + 3);
    chk("timeout_sticky", int'(timeout), 1);
    chk("timeout_busy_low", int'(busy), 0);
`endif

    repeat (10) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_txn_sequencer.md
# axi_txn_sequencer

Stimulus sequencer for the AXI BRAM verification top. It sits directly upstream of `axi_verif_top` and drives its `start_write_txn` / `start_read_txn` inputs with single-cycle pulses. It runs a programmable number of write-then-read iterations, waiting on the master's completion signals between them. It reports progress, a saturating read-error count and an overall pass/fail result, so benches and on-board tests no longer hand-time pulses with fixed delays.

## Interface
- `ITER_W`, 8: width of the iteration count and the error count.
- `GAP_CYCLES`, 16: idle cycles inserted before every write pulse and every read pulse (≥1).
- `TIMEOUT_CYCLES`, 1024: watchdog limit per wait state, in cycles (≥2).
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `num_iters`  in  ITER_W  number of write+read iterations; sampled on accepted `start`.
- `write_done`  in  1  one-cycle pulse from the master when the write burst completes.
- `read_done`  in  1  one-cycle pulse from the master when the read burst completes.
- `read_error`  in  1  read data mismatch; valid only in the `read_done` cycle.
- `start_write_txn`  out  1  one-cycle pulse to `axi_verif_top`.
- `start_read_txn`  out  1  one-cycle pulse to `axi_verif_top`.
- `busy`  out  1  high from the accepted `start` until DONE is left.
- `done`  out  1  one-cycle pulse when a run ends.
- `pass`  out  1  run result; held until the next accepted `start`.
- `iter_count`  out  ITER_W  completed iterations in the current or last run.
- `error_count`  out  ITER_W  read errors plus timeouts; saturates at all-ones.
- `timeout`  out  1  sticky watchdog flag; cleared on an accepted `start`.

## Operation
- FSM states: IDLE, GAP_W, WR_PULSE, WR_WAIT, GAP_R, RD_PULSE, RD_WAIT, DONE.
- IDLE:
  - `start` = 1 with `num_iters` ≠ 0: latch `num_iters`, clear both counts, `timeout` and `pass`, then go to GAP_W.
  - `start` = 1 with `num_iters` = 0: go straight to DONE with `pass` = 1; no pulses are issued.
- GAP_W / GAP_R: count `GAP_CYCLES` cycles, then go to WR_PULSE / RD_PULSE.
- WR_PULSE / RD_PULSE: the matching `start_*_txn` output is high for exactly this one cycle. Next state is WR_WAIT / RD_WAIT.
- WR_WAIT: on `write_done`, go to GAP_R.
- RD_WAIT: on `read_done`:
  - Increment `iter_count`.
  - If `read_error` = 1, increment `error_count` (saturating).
  - If `iter_count` + 1 equals the latched `num_iters`, go to DONE; otherwise go to GAP_W.
- DONE: `done` = 1 for one cycle, with `pass` = (`error_count` == 0) using the final count. Next state is IDLE.
- `start` outside IDLE is ignored.
- `write_done` / `read_done` outside their own wait state are ignored. This includes a done pulse that arrives in the same cycle as the issuing pulse.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-run: the run is aborted at the next edge. No further pulses are issued and no `done` is produced.
- Latency from accepted `start` to `start_write_txn`: `GAP_CYCLES` + 1 cycles.
- Latency from `write_done` to `start_read_txn`: `GAP_CYCLES` + 1 cycles.
- Latency from the final `read_done` to `done`: 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- `busy` is 1 in every state except IDLE, including the DONE cycle.
- `iter_count` wraps naturally; it cannot exceed `num_iters` because the run stops there.

## Configuration
- `AXI_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WR_WAIT / RD_WAIT.
  - After `TIMEOUT_CYCLES` cycles without the expected done pulse: set `timeout`, increment `error_count`, go to DONE with `pass` = 0.
  - A done pulse arriving in the expiry cycle wins over the timeout.
- Not defined: the block waits indefinitely; `timeout` is tied to 0 and the watchdog logic is absent.

## Structure
- `axi_seq_pkg` holds:
  - the state enum `axi_seq_state_e`;
  - default constants `AXI_SEQ_GAP_DEFAULT` and `AXI_SEQ_TIMEOUT_DEFAULT`.
- Sub-module `axi_seq_timer`: a loadable down-counter with a zero flag, instantiated twice.
  - Gap instance: always present.
  - Watchdog instance: present only under `AXI_SEQ_TIMEOUT_EN`.

## Test plan
- `num_iters` = 1, the master answers each pulse with done after 40 cycles, no errors:
  - exactly one write pulse, then one read pulse;
  - `done` arrives 1 cycle after `read_done`, with `pass` = 1 and `iter_count` = 1.
- `num_iters` = 3, `read_error` = 1 on the second `read_done` only:
  - 3 write/read pulse pairs;
  - `error_count` = 1, `pass` = 0.
- `start` pulsed again during WR_WAIT, plus a stray `read_done` during WR_WAIT:
  - both are ignored;
  - the pulse sequence and counts are unchanged.
- `num_iters` = 0:
  - `done` occurs 1 cycle after `start` with `pass` = 1;
  - no `start_*_txn` pulses.
- `reset` driven low during RD_WAIT for one cycle:
  - all outputs read 0 on the next cycle;
  - no `done`;
  - a new `start` runs normally.
- With `AXI_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 64, `write_done` never arrives:
  - `timeout` = 1 after 64 cycles in WR_WAIT;
  - `error_count` = 1, `pass` = 0, then `done`.
